// File: rtl/spike_rate_decoder_pkg.sv
// Shared types and helpers for the spike rate decoder: FSM states, default sizes, saturating increment.
package spike_dec_pkg;

    localparam int WIN_LOG2_DEF = 8;
    localparam int CNT_W_DEF    = 8;
    localparam int ISI_W_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT1,
        WAIT2,
        TRACK
    } state_e;

    // Increment that sticks at 2**width-1; callers truncate the result back to width bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_v;
        max_v = (32'd1 << width) - 32'd1;
        return (value >= max_v) ? max_v : value + 32'd1;
    endfunction

endpackage

// File: rtl/spike_rate_decoder_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency 1 cycle from clr_i/inc_i to cnt_o; no backpressure.
module sat_counter
    import spike_dec_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = W'(sat_inc(32'(cnt_q), W));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike train to rate/ISI decoder; result appears 1 cycle after a window closes.
// One-entry result register: a close while a result is unconsumed drops it and sets sticky overrun.
module spike_rate_decoder
    import spike_dec_pkg::*;
#(
    parameter int WIN_LOG2 = WIN_LOG2_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int ISI_W    = ISI_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             spike_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] rate_cnt,
    output logic [ISI_W-1:0] isi_cyc,
    output logic             isi_valid,
    output logic             overrun
);

    state_e               state_q, state_d;
    logic                 spike_q;
    logic [WIN_LOG2-1:0]  win_q, win_d;
    logic [ISI_W-1:0]     last_isi_q, last_isi_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_W-1:0]     rate_q, rate_d;
    logic [ISI_W-1:0]     isi_q, isi_d;
    logic                 overrun_q, overrun_d;

    logic [CNT_W-1:0]     spk_cnt;
    logic [ISI_W-1:0]     isi_cnt;
    logic                 ev;
    logic                 close;
    logic                 capture;
    logic                 load;
    logic [ISI_W-1:0]     isi_inc;
    logic [CNT_W-1:0]     rate_snap;
    logic [ISI_W-1:0]     isi_snap;

    assign ev        = spike_in & ~spike_q & en;
    assign close     = en & (&win_q);
    assign capture   = ev & ((state_q == WAIT2) | (state_q == TRACK));
    assign isi_inc   = ISI_W'(sat_inc(32'(isi_cnt), ISI_W));
    // A spike on the closing cycle belongs to the window being closed.
    assign rate_snap = ev ? CNT_W'(sat_inc(32'(spk_cnt), CNT_W)) : spk_cnt;
    assign isi_snap  = capture ? isi_inc : last_isi_q;
    assign load      = close & (~out_valid_q | out_ready);

    sat_counter #(.W(CNT_W)) u_spk_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (~en | close),
        .inc_i (ev),
        .cnt_o (spk_cnt)
    );

    sat_counter #(.W(ISI_W)) u_isi_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (~en | ev),
        .inc_i (en),
        .cnt_o (isi_cnt)
    );

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = WAIT1;
                WAIT1:   if (ev) state_d = WAIT2;
                WAIT2:   if (ev) state_d = TRACK;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        win_d      = en ? win_q + WIN_LOG2'(1) : '0;
        last_isi_d = last_isi_q;
        if (!en) begin
            last_isi_d = '0;
        end else if (capture) begin
            last_isi_d = isi_inc;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        rate_d      = rate_q;
        isi_d       = isi_q;
        overrun_d   = overrun_q;
        if (load) begin
            out_valid_d = 1'b1;
            rate_d      = rate_snap;
            isi_d       = isi_snap;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (close && out_valid_q && !out_ready) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            spike_q     <= 1'b0;
            win_q       <= '0;
            last_isi_q  <= '0;
            out_valid_q <= 1'b0;
            rate_q      <= '0;
            isi_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            spike_q     <= spike_in;
            win_q       <= win_d;
            last_isi_q  <= last_isi_d;
            out_valid_q <= out_valid_d;
            rate_q      <= rate_d;
            isi_q       <= isi_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign rate_cnt  = rate_q;
    assign isi_cyc   = isi_q;
    assign isi_valid = (state_q == TRACK);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: 256-cycle and 1024-cycle window instances, scoreboard per instance.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    logic       en8 = 1'b0, spk8 = 1'b0, rdy8 = 1'b1;
    logic       vld8, iv8, ov8;
    logic [7:0] rate8, isi8;

    logic       en10 = 1'b0, spk10 = 1'b0, rdy10 = 1'b1;
    logic       vld10, iv10, ov10;
    logic [7:0] rate10, isi10;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] q8[$];
    logic [15:0] q10[$];
    logic [15:0] e8, e10;

    spike_rate_decoder #(.WIN_LOG2(8), .CNT_W(8), .ISI_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en8), .spike_in(spk8), .out_ready(rdy8),
        .out_valid(vld8), .rate_cnt(rate8), .isi_cyc(isi8), .isi_valid(iv8), .overrun(ov8)
    );

    spike_rate_decoder #(.WIN_LOG2(10), .CNT_W(8), .ISI_W(8)) u_dut10 (
        .clk(clk), .rst(rst), .en(en10), .spike_in(spk10), .out_ready(rdy10),
        .out_valid(vld10), .rate_cnt(rate10), .isi_cyc(isi10), .isi_valid(iv10), .overrun(ov10)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && vld8 && rdy8) begin
            if (q8.size() == 0) begin
                n_total++;
                $display("FAIL dut8_unexpected_result: got rate %0d isi %0d, expected no result", rate8, isi8);
            end else begin
                e8 = q8.pop_front();
                check("dut8_rate", int'(rate8), int'(e8[15:8]));
                check("dut8_isi", int'(isi8), int'(e8[7:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && vld10 && rdy10) begin
            if (q10.size() == 0) begin
                n_total++;
                $display("FAIL dut10_unexpected_result: got rate %0d isi %0d, expected no result", rate10, isi10);
            end else begin
                e10 = q10.pop_front();
                check("dut10_rate", int'(rate10), int'(e10[15:8]));
                check("dut10_isi", int'(isi10), int'(e10[7:0]));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", int'(vld8), 0);
        check("reset_rate", int'(rate8), 0);
        check("reset_isi", int'(isi8), 0);
        check("reset_isi_valid", int'(iv8), 0);
        check("reset_overrun", int'(ov8), 0);
        rst = 1'b0;
        cyc();

        // Regular spikes every 16 cycles over three windows.
        en8 = 1'b1;
        for (int c = 0; c < 768; c++) begin
            spk8 = (c % 16 == 3);
            if (c % 256 == 0) q8.push_back({8'd16, 8'd16});
            cyc();
            if (c == 10) check("periodic_isi_valid_early", int'(iv8), 0);
            if (c == 30) check("periodic_isi_valid_track", int'(iv8), 1);
        end

        // Abort mid-window: that window yields nothing, the next one starts from zero.
        for (int c = 0; c < 100; c++) begin
            spk8 = (c % 16 == 3);
            cyc();
        end
        en8 = 1'b0;
        spk8 = 1'b0;
        cyc();
        check("abort_isi_valid", int'(iv8), 0);
        repeat (4) cyc();
        en8 = 1'b1;
        q8.push_back({8'd8, 8'd32});
        for (int c = 0; c < 256; c++) begin
            spk8 = (c % 32 == 5);
            cyc();
        end

        // Held-high spike: one event per window.
        spk8 = 1'b0;
        en8 = 1'b0;
        repeat (5) cyc();
        en8 = 1'b1;
        q8.push_back({8'd1, 8'd0});
        q8.push_back({8'd1, 8'd255});
        for (int c = 0; c < 512; c++) begin
            spk8 = ((c % 256) >= 10) && ((c % 256) < 50);
            cyc();
            if (c == 200) check("held_isi_valid_w0", int'(iv8), 0);
            if (c == 300) check("held_isi_valid_w1", int'(iv8), 1);
        end

        // Backpressure across two closes: first result held, second dropped.
        en8 = 1'b0;
        spk8 = 1'b0;
        repeat (5) cyc();
        rdy8 = 1'b0;
        en8 = 1'b1;
        q8.push_back({8'd4, 8'd64});
        q8.push_back({8'd16, 8'd16});
        for (int c = 0; c < 768; c++) begin
            int per;
            per = (c < 256) ? 64 : ((c < 512) ? 32 : 16);
            spk8 = (c % per == 3);
            rdy8 = (c >= 520);
            cyc();
            if (c == 300) begin
                check("bp_valid_held", int'(vld8), 1);
                check("bp_rate_held", int'(rate8), 4);
                check("bp_isi_held", int'(isi8), 64);
                check("bp_overrun_before", int'(ov8), 0);
            end
            if (c == 515) begin
                check("bp_overrun_after", int'(ov8), 1);
                check("bp_rate_after_drop", int'(rate8), 4);
                check("bp_isi_after_drop", int'(isi8), 64);
            end
            if (c == 530) check("bp_valid_dropped", int'(vld8), 0);
        end

        // Asynchronous reset with a pending result and a tracking FSM.
        spk8 = 1'b0;
        cyc();
        rdy8 = 1'b0;
        for (int k = 0; k < 400; k++) begin
            spk8 = (k % 16 == 3);
            cyc();
        end
        check("pre_rst_valid", int'(vld8), 1);
        check("pre_rst_isi_valid", int'(iv8), 1);
        #3 rst = 1'b1;
        #1;
        check("rst_out_valid", int'(vld8), 0);
        check("rst_rate", int'(rate8), 0);
        check("rst_isi", int'(isi8), 0);
        check("rst_isi_valid", int'(iv8), 0);
        check("rst_overrun", int'(ov8), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy8 = 1'b1;
        q8.push_back({8'd16, 8'd16});
        for (int c = 0; c < 256; c++) begin
            spk8 = (c % 16 == 3);
            cyc();
            if (c == 250) check("post_rst_no_valid", int'(vld8), 0);
        end
        spk8 = 1'b0;
        cyc();
        en8 = 1'b0;
        cyc();

        // Saturation on the 1024-cycle instance.
        en10 = 1'b1;
        q10.push_back({8'd255, 8'd2});
        for (int c = 0; c < 1024; c++) begin
            spk10 = (c % 2 == 0);
            cyc();
        end
        en10 = 1'b0;
        spk10 = 1'b0;
        repeat (5) cyc();
        en10 = 1'b1;
        q10.push_back({8'd4, 8'd255});
        for (int c = 0; c < 1024; c++) begin
            spk10 = (c % 300 == 5);
            cyc();
        end
        en10 = 1'b0;
        spk10 = 1'b0;
        repeat (3) cyc();

        check("dut8_results_outstanding", q8.size(), 0);
        check("dut10_results_outstanding", q10.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
